// File: rtl/udma_external_per_core_if.sv
// Stream bundle between the uDMA channel, the external-peripheral core and the peripheral pins.
// The core uses the slave modport; the uDMA/peripheral side uses the master modport.
interface udma_external_per_core_if;
  logic [31:0] data_tx_i;
  logic [1:0]  data_tx_datasize_i;
  logic        data_tx_valid_i;
  logic        data_tx_ready_o;
  logic [7:0]  ext_tx_data_o;
  logic        ext_tx_valid_o;
  logic        ext_tx_ready_i;
  logic [7:0]  ext_rx_data_i;
  logic        ext_rx_valid_i;
  logic        ext_rx_ready_o;
  logic [1:0]  data_rx_datasize_i;
  logic [31:0] data_rx_o;
  logic        data_rx_valid_o;
  logic        data_rx_ready_i;

  modport slave (
    input  data_tx_i, data_tx_datasize_i, data_tx_valid_i,
    output data_tx_ready_o,
    output ext_tx_data_o, ext_tx_valid_o,
    input  ext_tx_ready_i,
    input  ext_rx_data_i, ext_rx_valid_i,
    output ext_rx_ready_o,
    input  data_rx_datasize_i,
    output data_rx_o, data_rx_valid_o,
    input  data_rx_ready_i
  );

  modport master (
    output data_tx_i, data_tx_datasize_i, data_tx_valid_i,
    input  data_tx_ready_o,
    input  ext_tx_data_o, ext_tx_valid_o,
    output ext_tx_ready_i,
    output ext_rx_data_i, ext_rx_valid_i,
    input  ext_rx_ready_o,
    output data_rx_datasize_i,
    input  data_rx_o, data_rx_valid_o,
    output data_rx_ready_i
  );
endinterface

// File: rtl/udma_external_per_core.sv
// External peripheral datapath: unpacks uDMA TX words into bytes and packs RX bytes
// into uDMA words, with an idle timeout that flushes partially filled RX words.
module udma_external_per_core #(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [31:0]               cfg_setup_i,
  output logic [31:0]               status_o,
  udma_external_per_core_if.slave   bus
);

  typedef enum logic [0:0] {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_e;

  // Index of the last byte lane for a datasize code (sizes 2 and 3 both mean 4 bytes).
  function automatic logic [1:0] size_last(input logic [1:0] datasize);
    logic [1:0] last;
    case (datasize)
      2'd0:    last = 2'd0;
      2'd1:    last = 2'd1;
      default: last = 2'd3;
    endcase
    return last;
  endfunction

  tx_state_e             tx_state_r;
  logic [31:0]           tx_word_r;
  logic [1:0]            tx_idx_r;
  logic [1:0]            tx_last_r;

  logic [31:0]           rx_data_r;
  logic [1:0]            rx_cnt_r;
  logic [1:0]            rx_last_r;
  logic                  rx_valid_r;
  logic [TIMEOUT_W-1:0]  rx_timer_r;
  logic [7:0]            flush_cnt_r;

  logic                  enable_s;
  logic [TIMEOUT_W-1:0]  rx_timeout_s;
  logic [TIMEOUT_W-1:0]  rx_timer_nxt_s;
  logic [1:0]            rx_tgt_last_s;
  logic                  rx_acc_s;
  logic                  rx_pop_s;
  logic                  unused_cfg_s;

  // Holding rst_i also gates the handshakes so every output reads 0 during reset.
  assign enable_s       = cfg_setup_i[0] & ~rst_i;
  assign rx_timeout_s   = cfg_setup_i[8 +: TIMEOUT_W];
  assign unused_cfg_s   = ^{cfg_setup_i[31:8+TIMEOUT_W], cfg_setup_i[7:1]};
  assign rx_timer_nxt_s = rx_timer_r + TIMEOUT_W'(1);
  assign rx_acc_s       = enable_s & ~rx_valid_r & bus.ext_rx_valid_i;
  assign rx_pop_s       = enable_s & rx_valid_r & bus.data_rx_ready_i;
  assign rx_tgt_last_s  = (rx_cnt_r == 2'd0) ? size_last(bus.data_rx_datasize_i) : rx_last_r;

  assign bus.data_tx_ready_o = enable_s & (tx_state_r == TX_IDLE);
  assign bus.ext_tx_valid_o  = enable_s & (tx_state_r == TX_SHIFT);
  assign bus.ext_tx_data_o   = tx_word_r[{tx_idx_r, 3'b000} +: 8];
  assign bus.ext_rx_ready_o  = enable_s & ~rx_valid_r;
  assign bus.data_rx_o       = rx_data_r;
  assign bus.data_rx_valid_o = enable_s & rx_valid_r;

  assign status_o = {16'h0000, flush_cnt_r, tx_idx_r, rx_cnt_r, 1'b0,
                     (rx_cnt_r != 2'd0), rx_valid_r, (tx_state_r == TX_SHIFT)};

  // TX unpacker FSM: capture a word in IDLE, emit its bytes LSB first in SHIFT.
  always_ff @(posedge clk_i) begin
    if (rst_i || !cfg_setup_i[0]) begin
      tx_state_r <= TX_IDLE;
      tx_word_r  <= 32'h0000_0000;
      tx_idx_r   <= 2'd0;
      tx_last_r  <= 2'd0;
    end else begin
      case (tx_state_r)
        TX_IDLE: begin
          if (bus.data_tx_valid_i) begin
            tx_word_r  <= bus.data_tx_i;
            tx_last_r  <= size_last(bus.data_tx_datasize_i);
            tx_idx_r   <= 2'd0;
            tx_state_r <= TX_SHIFT;
          end else begin
            tx_state_r <= TX_IDLE;
          end
        end
        TX_SHIFT: begin
          if (bus.ext_tx_ready_i) begin
            if (tx_idx_r == tx_last_r) begin
              tx_idx_r   <= 2'd0;
              tx_state_r <= TX_IDLE;
            end else begin
              tx_idx_r   <= tx_idx_r + 2'd1;
            end
          end else begin
            tx_state_r <= TX_SHIFT;
          end
        end
        default: begin
          tx_state_r <= TX_IDLE;
          tx_idx_r   <= 2'd0;
        end
      endcase
    end
  end

  // RX packer with idle-timeout flush; an arriving byte always beats an expiring timer.
  always_ff @(posedge clk_i) begin
    if (rst_i || !cfg_setup_i[0]) begin
      rx_data_r   <= 32'h0000_0000;
      rx_cnt_r    <= 2'd0;
      rx_last_r   <= 2'd0;
      rx_valid_r  <= 1'b0;
      rx_timer_r  <= {TIMEOUT_W{1'b0}};
      flush_cnt_r <= 8'd0;
    end else if (rx_acc_s) begin
      rx_timer_r <= {TIMEOUT_W{1'b0}};
      if (rx_cnt_r == 2'd0) begin
        rx_data_r <= {24'h00_0000, bus.ext_rx_data_i};
        rx_last_r <= rx_tgt_last_s;
      end else begin
        rx_data_r[{rx_cnt_r, 3'b000} +: 8] <= bus.ext_rx_data_i;
      end
      if (rx_cnt_r == rx_tgt_last_s) begin
        rx_valid_r <= 1'b1;
        rx_cnt_r   <= 2'd0;
      end else begin
        rx_cnt_r   <= rx_cnt_r + 2'd1;
      end
    end else if (rx_pop_s) begin
      rx_valid_r <= 1'b0;
    end else if (!rx_valid_r && (rx_cnt_r != 2'd0)) begin
      if ((rx_timeout_s != {TIMEOUT_W{1'b0}}) && (rx_timer_nxt_s == rx_timeout_s)) begin
        rx_valid_r <= 1'b1;
        rx_cnt_r   <= 2'd0;
        rx_timer_r <= {TIMEOUT_W{1'b0}};
        if (flush_cnt_r != 8'hFF) begin
          flush_cnt_r <= flush_cnt_r + 8'd1;
        end else begin
          flush_cnt_r <= flush_cnt_r;
        end
      end else if (rx_timer_r != {TIMEOUT_W{1'b1}}) begin
        rx_timer_r <= rx_timer_nxt_s;
      end else begin
        rx_timer_r <= rx_timer_r;
      end
    end else begin
      rx_timer_r <= rx_timer_r;
    end
  end

endmodule

// File: tb/tb_udma_external_per_core.sv
// Directed bench for udma_external_per_core: TX unpacking, RX packing, timeout flush,
// disable and reset aborts, all against hand-computed values.
module tb_udma_external_per_core;

  logic        clk;
  logic        rst_i;
  logic [31:0] cfg;
  logic [31:0] status;
  int          n_checks;
  int          n_errors;

  udma_external_per_core_if bus_if ();

  udma_external_per_core #(.TIMEOUT_W(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cfg_setup_i (cfg),
    .status_o    (status),
    .bus         (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected normal completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bus_if.ext_rx_data_i  = b;
    bus_if.ext_rx_valid_i = 1'b1;
    tick();
    bus_if.ext_rx_valid_i = 1'b0;
  endtask

  task automatic rx_accept();
    bus_if.data_rx_ready_i = 1'b1;
    tick();
    bus_if.data_rx_ready_i = 1'b0;
  endtask

  task automatic check_all_idle(input string tag);
    #1;
    check({tag, "_txrdy"},  {31'd0, bus_if.data_tx_ready_o}, 32'd0);
    check({tag, "_txval"},  {31'd0, bus_if.ext_tx_valid_o},  32'd0);
    check({tag, "_rxrdy"},  {31'd0, bus_if.ext_rx_ready_o},  32'd0);
    check({tag, "_rxval"},  {31'd0, bus_if.data_rx_valid_o}, 32'd0);
  endtask

  logic [31:0] word;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_i = 1'b1;
    cfg   = 32'h0000_0000;
    bus_if.data_tx_i          = 32'h0;
    bus_if.data_tx_datasize_i = 2'd0;
    bus_if.data_tx_valid_i    = 1'b0;
    bus_if.ext_tx_ready_i     = 1'b0;
    bus_if.ext_rx_data_i      = 8'h00;
    bus_if.ext_rx_valid_i     = 1'b0;
    bus_if.data_rx_datasize_i = 2'd0;
    bus_if.data_rx_ready_i    = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;
    #1;
    check("rst_status", status, 32'h0);
    check("rst_rxdata", bus_if.data_rx_o, 32'h0);
    check("rst_txdata", {24'd0, bus_if.ext_tx_data_o}, 32'h0);
    check_all_idle("rst");

    // TX 4-byte word with the peripheral always ready
    cfg = 32'h0000_0001;
    bus_if.data_tx_i          = 32'hDDCC_BBAA;
    bus_if.data_tx_datasize_i = 2'd2;
    bus_if.data_tx_valid_i    = 1'b1;
    bus_if.ext_tx_ready_i     = 1'b1;
    #1;
    check("tx4_rdy0", {31'd0, bus_if.data_tx_ready_o}, 32'd1);
    tick();
    bus_if.data_tx_valid_i = 1'b0;
    word = 32'hDDCC_BBAA;
    for (int i = 0; i < 4; i++) begin
      check("tx4_val",  {31'd0, bus_if.ext_tx_valid_o}, 32'd1);
      check("tx4_byte", {24'd0, bus_if.ext_tx_data_o}, {24'd0, word[8*i +: 8]});
      check("tx4_stat", status, 32'h1 | (i << 6));
      check("tx4_busy", {31'd0, bus_if.data_tx_ready_o}, 32'd0);
      tick();
    end
    check("tx4_done_val", {31'd0, bus_if.ext_tx_valid_o}, 32'd0);
    check("tx4_done_rdy", {31'd0, bus_if.data_tx_ready_o}, 32'd1);

    // TX 1-byte word, byte held while the peripheral stalls
    bus_if.data_tx_i          = 32'h1234_5678;
    bus_if.data_tx_datasize_i = 2'd0;
    bus_if.data_tx_valid_i    = 1'b1;
    bus_if.ext_tx_ready_i     = 1'b0;
    tick();
    bus_if.data_tx_valid_i = 1'b0;
    check("tx1_byte", {24'd0, bus_if.ext_tx_data_o}, 32'h78);
    tick();
    check("tx1_hold_val",  {31'd0, bus_if.ext_tx_valid_o}, 32'd1);
    check("tx1_hold_byte", {24'd0, bus_if.ext_tx_data_o}, 32'h78);
    bus_if.ext_tx_ready_i = 1'b1;
    tick();
    bus_if.ext_tx_ready_i = 1'b0;
    check("tx1_done", {31'd0, bus_if.ext_tx_valid_o}, 32'd0);

    // TX 2-byte word
    bus_if.data_tx_datasize_i = 2'd1;
    bus_if.data_tx_valid_i    = 1'b1;
    bus_if.ext_tx_ready_i     = 1'b1;
    tick();
    bus_if.data_tx_valid_i = 1'b0;
    check("tx2_b0", {24'd0, bus_if.ext_tx_data_o}, 32'h78);
    tick();
    check("tx2_b1", {24'd0, bus_if.ext_tx_data_o}, 32'h56);
    tick();
    check("tx2_done", {31'd0, bus_if.ext_tx_valid_o}, 32'd0);

    // RX full 4-byte word with back-pressure from the uDMA
    bus_if.data_rx_datasize_i = 2'd2;
    rx_byte(8'h01);
    rx_byte(8'h02);
    check("rx4_mid_stat", status, 32'h24);
    rx_byte(8'h03);
    rx_byte(8'h04);
    repeat (2) tick();
    check("rx4_val",  {31'd0, bus_if.data_rx_valid_o}, 32'd1);
    check("rx4_data", bus_if.data_rx_o, 32'h0403_0201);
    check("rx4_rdy",  {31'd0, bus_if.ext_rx_ready_o}, 32'd0);
    check("rx4_stat", status, 32'h02);
    rx_accept();
    check("rx4_pop_val", {31'd0, bus_if.data_rx_valid_o}, 32'd0);
    check("rx4_pop_rdy", {31'd0, bus_if.ext_rx_ready_o}, 32'd1);

    // RX timeout 5 flushes a 2-byte partial word
    cfg = 32'h0000_0501;
    rx_byte(8'hAA);
    rx_byte(8'hBB);
    repeat (4) tick();
    check("to_early", {31'd0, bus_if.data_rx_valid_o}, 32'd0);
    tick();
    check("to_val",  {31'd0, bus_if.data_rx_valid_o}, 32'd1);
    check("to_data", bus_if.data_rx_o, 32'h0000_BBAA);
    check("to_stat", status, 32'h0102);
    rx_accept();

    // A byte arriving on the expiry cycle wins over the flush
    rx_byte(8'hAA);
    rx_byte(8'hBB);
    repeat (4) tick();
    rx_byte(8'hCC);
    check("to_race_val",  {31'd0, bus_if.data_rx_valid_o}, 32'd0);
    check("to_race_stat", status, 32'h0134);
    rx_byte(8'hDD);
    check("to_race_data", bus_if.data_rx_o, 32'hDDCC_BBAA);
    rx_accept();
    check("to_race_end", status, 32'h0100);

    // Timeout 0 never flushes
    cfg = 32'h0000_0001;
    rx_byte(8'h11);
    repeat (20) tick();
    check("to0_val",  {31'd0, bus_if.data_rx_valid_o}, 32'd0);
    check("to0_stat", status, 32'h0114);

    // Disable clears everything, including the flush counter
    cfg = 32'h0000_0000;
    tick();
    check("dis0_stat", status, 32'h0);

    // Disable mid-RX (cnt=3) and mid-TX (2 of 4 bytes sent)
    cfg = 32'h0000_0001;
    bus_if.data_rx_datasize_i = 2'd2;
    rx_byte(8'hA1);
    rx_byte(8'hA2);
    rx_byte(8'hA3);
    bus_if.data_tx_i          = 32'h4433_2211;
    bus_if.data_tx_datasize_i = 2'd2;
    bus_if.data_tx_valid_i    = 1'b1;
    bus_if.ext_tx_ready_i     = 1'b1;
    tick();
    bus_if.data_tx_valid_i = 1'b0;
    repeat (2) tick();
    bus_if.ext_tx_ready_i = 1'b0;
    check("mid_stat", status, 32'hB5);
    check("mid_byte", {24'd0, bus_if.ext_tx_data_o}, 32'h33);
    cfg = 32'h0000_0000;
    check_all_idle("dis");
    tick();
    check("dis_stat", status, 32'h0);
    cfg = 32'h0000_0001;
    #1;
    check("reen_txrdy", {31'd0, bus_if.data_tx_ready_o}, 32'd1);
    check("reen_rxrdy", {31'd0, bus_if.ext_rx_ready_o}, 32'd1);
    bus_if.data_tx_i          = 32'h0000_00EE;
    bus_if.data_tx_datasize_i = 2'd0;
    bus_if.data_tx_valid_i    = 1'b1;
    bus_if.ext_tx_ready_i     = 1'b1;
    tick();
    bus_if.data_tx_valid_i = 1'b0;
    check("reen_txbyte", {24'd0, bus_if.ext_tx_data_o}, 32'hEE);
    tick();
    check("reen_txdone", status, 32'h0);
    bus_if.data_rx_datasize_i = 2'd0;
    rx_byte(8'h5A);
    check("reen_rxdata", bus_if.data_rx_o, 32'h0000_005A);
    check("reen_rxval",  {31'd0, bus_if.data_rx_valid_o}, 32'd1);
    rx_accept();

    // Reset pulse mid-operation
    bus_if.data_rx_datasize_i = 2'd2;
    rx_byte(8'h77);
    bus_if.data_tx_i          = 32'h4433_2211;
    bus_if.data_tx_datasize_i = 2'd2;
    bus_if.data_tx_valid_i    = 1'b1;
    tick();
    bus_if.data_tx_valid_i = 1'b0;
    tick();
    check("prerst_stat", status, 32'h55);
    rst_i = 1'b1;
    check_all_idle("rstp");
    tick();
    check("rstp_stat", status, 32'h0);
    rst_i = 1'b0;
    bus_if.data_rx_datasize_i = 2'd0;
    rx_byte(8'h66);
    check("rstp_rxdata", bus_if.data_rx_o, 32'h0000_0066);
    check("rstp_rxstat", status, 32'h02);
    rx_accept();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
